wb_master_ctrl: RTL and testbench
=================================

# wb_master_ctrl

Synthesizable, parametrised Wishbone classic master for the SPI core's register bus. It replaces the task-driven master with a command/response handshake. Single and incrementing-address block reads and writes are issued from a command port, with per-beat write-data flow control and read-data return. Cycles terminate on ack, error or (optionally) a watchdog timeout, and completion status is reported to the requester.

## Interface
- ADR_W, 5, Wishbone word-address width
- DAT_W, 32, data width (multiple of 8)
- SEL_W, DAT_W/8, byte-select width
- MAX_LEN, 16, maximum beats per command (power of 2, ≥2); LEN_W = $clog2(MAX_LEN)
- TIMEOUT, 255, watchdog limit in cycles (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk_in  in  1  bus clock, all logic on rising edge
- rst_n_in  in  1  asynchronous active-low reset
- cmd_valid_in  in  1  command offered
- cmd_ready_o  out  1  master idle, command accepted when valid&ready
- cmd_we_in  in  1  1 = write, 0 = read
- cmd_adr_in  in  ADR_W  start word address
- cmd_sel_in  in  SEL_W  byte selects, applied to all beats
- cmd_len_in  in  LEN_W  beat count minus 1
- wr_dat_in  in  DAT_W  write data for next beat
- wr_valid_in  in  1  write data offered
- wr_ready_o  out  1  write data accepted when valid&ready
- rd_dat_o  out  DAT_W  read data
- rd_valid_o  out  1  one-cycle strobe per read beat
- done_o  out  1  one-cycle command-complete strobe
- status_o  out  2  00 OK, 01 ERR, 10 TIMEOUT; valid with done_o, held until the next done_o
- adr_o, dat_o, sel_o, we_o, cyc_o, stb_o  out  ADR_W/DAT_W/SEL_W/1/1/1  Wishbone master outputs, all registered
- dat_in, ack_in, err_in  in  DAT_W/1/1  Wishbone slave response

## Operation
- States: IDLE, WDAT, STRB, DONE.
- Reset forces IDLE. While reset is asserted, all registered outputs are 0, rd_valid_o and done_o are 0, and status_o is 00.
- cmd_ready_o = (state==IDLE) is a combinational decode of state, so it reads 1 during reset. wr_ready_o = (state==WDAT), so it reads 0 during reset.
- IDLE: on cmd_valid_in&cmd_ready_o, latch we, adr, sel and beat counter = len.
  - Write: go to WDAT.
  - Read: go to STRB, driving cyc_o=stb_o=1, we_o=0, adr_o, sel_o.
- WDAT: cyc_o stays at its current value (0 before the first beat, 1 between beats) and stb_o=0. On wr_valid_in, register dat_o, drive cyc_o=stb_o=we_o=1 and go to STRB.
- STRB: wait for slave termination.
  - err_in (wins over a simultaneous ack_in): drop cyc_o/stb_o/we_o, status ERR, go to DONE. Remaining beats are discarded.
  - ack_in with counter>0: decrement the counter and set adr_o+1, wrapping modulo 2^ADR_W.
    - Read: stay in STRB with stb_o held high; capture dat_in and pulse rd_valid_o.
    - Write: go to WDAT with stb_o low and cyc_o held high.
  - ack_in with counter==0: capture and strobe read data (reads only), drop cyc_o/stb_o/we_o, status OK, go to DONE.
- DONE: pulse done_o for one cycle, then go to IDLE.
- After completion, adr_o, sel_o and dat_o hold their last values; slaves qualify them with stb_o.
- A reset mid-command aborts immediately. cyc_o/stb_o fall asynchronously and no done_o is produced.

## Timing
- Read command accepted at edge N: cyc_o/stb_o are high after edge N.
- An ack sampled at edge M gives rd_dat_o/rd_valid_o valid after edge M. The next beat's address is also presented after edge M.
- A zero-wait slave (ack in the first stb_o cycle) gives back-to-back read beats, one per cycle.
- Write beat: wr_valid_in&wr_ready_o at edge N, then stb_o high after edge N.
  - Minimum two cycles per write beat: one WDAT cycle and one STRB cycle.
- After the final ack/err edge, done_o is high for one cycle. cmd_ready_o returns the following cycle.
- Command-to-command minimum gap: one cycle (the DONE cycle).

## Configuration
- WB_TIMEOUT_EN defined:
  - A watchdog counts consecutive STRB cycles without ack_in/err_in and clears on every termination.
  - When the count reaches TIMEOUT, the master drops cyc_o/stb_o, reports status TIMEOUT and goes to DONE.
- WB_TIMEOUT_EN undefined:
  - No counter is built and the master waits indefinitely.
  - status_o never reports 10, and TIMEOUT is ignored.

## Structure
- Package wb_master_pkg: state enum (IDLE, WDAT, STRB, DONE), status constants (ST_OK, ST_ERR, ST_TIMEOUT).
- Sub-module wb_watchdog: clear/enable inputs and an expired output, parametrised by TIMEOUT.
  - Instantiated only under WB_TIMEOUT_EN.

## Test plan
- Single write: we=1, adr=5'h03, sel=4'hF, len=0, data 32'hDEADBEEF; ack after 2 wait cycles -> one stb_o period with adr_o=3 and dat_o=DEADBEEF; done_o with status 00.
- 4-beat read from adr=5'h1E with a zero-wait slave -> adr_o sequence 1E,1F,00,01 (wrap), with stb_o high for 4 consecutive cycles and 4 rd_valid_o pulses carrying the slave data; status 00.
- Write burst len=2, with wr_valid_in withheld 3 cycles before beat 2 -> cyc_o stays high and stb_o stays low during the stall; 3 beats complete and done_o fires.
- Read len=3 with err_in on beat 2 (ack+err together) -> exactly 1 rd_valid_o and status 01; cyc_o drops after the err edge.
- WB_TIMEOUT_EN with TIMEOUT=8 and a slave that never acks -> stb_o high for 8 cycles, then drops; status 10.
- Without WB_TIMEOUT_EN, the same stimulus holds stb_o high for 1000 cycles.
- rst_n_in low mid-burst -> cyc_o/stb_o are 0 immediately, cmd_ready_o=1, and no done_o.
  - A new command after release runs normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// wb_master_pkg: FSM state and completion-status encodings shared by
// wb_master_ctrl and its testbench.
package wb_master_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WDAT = 2'd1;
  localparam state_t STRB = 2'd2;
  localparam state_t DONE = 2'd3;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_master_ctrl_watchdog.sv
// wb_watchdog: down-counter that expires after TIMEOUT consecutive enabled
// cycles. Reloads on clr; expired is asserted in the TIMEOUT-th cycle itself
// so the master can leave the strobe phase at that cycle's edge.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // count down while enabled, parked at zero until cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= RELOAD;
    else if (clr)                cnt <= RELOAD;
    else if (en && cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: Wishbone classic master with a command/response port.
// Single and incrementing block reads/writes, per-beat write flow control,
// read-data strobe, and a done/status report per command.
// Optional build macro WB_TIMEOUT_EN adds a strobe watchdog (wb_watchdog).
//
//   state | meaning
//   IDLE  | ready for a command
//   WDAT  | write: waiting for the next beat's data
//   STRB  | stb_o high, waiting for ack/err (or watchdog)
//   DONE  | done_o/status_o presented for one cycle
module wb_master_ctrl
  import wb_master_pkg::*;
#(
  parameter  int ADR_W   = 5,
  parameter  int DAT_W   = 32,
  parameter  int SEL_W   = DAT_W / 8,
  parameter  int MAX_LEN = 16,
  parameter  int TIMEOUT = 255,
  localparam int LEN_W   = $clog2(MAX_LEN)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             cmd_valid_in,
  output logic             cmd_ready_o,
  input  logic             cmd_we_in,
  input  logic [ADR_W-1:0] cmd_adr_in,
  input  logic [SEL_W-1:0] cmd_sel_in,
  input  logic [LEN_W-1:0] cmd_len_in,
  input  logic [DAT_W-1:0] wr_dat_in,
  input  logic             wr_valid_in,
  output logic             wr_ready_o,
  output logic [DAT_W-1:0] rd_dat_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic [SEL_W-1:0] sel_o,
  output logic             we_o,
  output logic             cyc_o,
  output logic             stb_o,
  input  logic [DAT_W-1:0] dat_in,
  input  logic             ack_in,
  input  logic             err_in
);

  if (DAT_W % 8 != 0 || SEL_W != DAT_W / 8) begin : g_bad_dat_w
    $error("DAT_W must be a multiple of 8 and SEL_W must equal DAT_W/8");
  end
  if (MAX_LEN < 2 || (MAX_LEN & (MAX_LEN - 1)) != 0) begin : g_bad_max_len
    $error("MAX_LEN must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t           state;
  logic             we_r;
  logic [LEN_W-1:0] beat_cnt;
  logic             timeout;
  logic             term;
  logic [1:0]       term_status;

  assign cmd_ready_o = (state == IDLE);
  assign wr_ready_o  = (state == WDAT);

`ifdef WB_TIMEOUT_EN
  wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .clr     ((state != STRB) || ack_in || err_in),
    .en      (state == STRB),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // how a strobe cycle ends: err beats ack, last ack completes, watchdog last
  always_comb begin
    term        = 1'b0;
    term_status = ST_OK;
    if (err_in) begin
      term        = 1'b1;
      term_status = ST_ERR;
    end else if (ack_in) begin
      term        = (beat_cnt == '0);
    end else if (timeout) begin
      term        = 1'b1;
      term_status = ST_TIMEOUT;
    end
  end

  // command sequencing and registered bus outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      we_r       <= 1'b0;
      beat_cnt   <= '0;
      adr_o      <= '0;
      dat_o      <= '0;
      sel_o      <= '0;
      we_o       <= 1'b0;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      rd_dat_o   <= '0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      status_o   <= ST_OK;
    end else begin
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_in) begin
            we_r     <= cmd_we_in;
            adr_o    <= cmd_adr_in;
            sel_o    <= cmd_sel_in;
            beat_cnt <= cmd_len_in;
            if (cmd_we_in) begin
              state <= WDAT;
            end else begin
              state <= STRB;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              we_o  <= 1'b0;
            end
          end
        end
        WDAT: begin
          if (wr_valid_in) begin
            dat_o <= wr_dat_in;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= 1'b1;
            state <= STRB;
          end
        end
        STRB: begin
          if (ack_in && !err_in && !we_r) begin
            rd_dat_o   <= dat_in;
            rd_valid_o <= 1'b1;
          end
          if (term) begin
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            status_o <= term_status;
            done_o   <= 1'b1;
            state    <= DONE;
          end else if (ack_in) begin
            beat_cnt <= beat_cnt - 1'b1;
            adr_o    <= adr_o + 1'b1;
            if (we_r) begin
              stb_o <= 1'b0;
              state <= WDAT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl: randomized and directed stimulus against a
// transaction-level model of the master's bus behaviour.
module tb_wb_master_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TO      = 8;
`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        cmd_valid_in, cmd_we_in, wr_valid_in;
  logic [4:0]  cmd_adr_in;
  logic [3:0]  cmd_sel_in, cmd_len_in;
  logic [31:0] wr_dat_in, dat_in;
  logic        ack_in, err_in;
  logic        cmd_ready_o, wr_ready_o, rd_valid_o, done_o, we_o, cyc_o, stb_o;
  logic [31:0] rd_dat_o, dat_o;
  logic [1:0]  status_o;
  logic [4:0]  adr_o;
  logic [3:0]  sel_o;

  wb_master_ctrl #(.ADR_W(5), .DAT_W(32), .SEL_W(4), .MAX_LEN(MAX_LEN), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_o(cmd_ready_o), .cmd_we_in(cmd_we_in),
    .cmd_adr_in(cmd_adr_in), .cmd_sel_in(cmd_sel_in), .cmd_len_in(cmd_len_in),
    .wr_dat_in(wr_dat_in), .wr_valid_in(wr_valid_in), .wr_ready_o(wr_ready_o),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o), .done_o(done_o), .status_o(status_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
    .dat_in(dat_in), .ack_in(ack_in), .err_in(err_in)
  );

  initial forever #5 clk_in = ~clk_in;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // slave behaviour knobs
  int sl_lo = 0, sl_hi = 0, sl_err_beat = -1, sl_beat = 0;

  // monitor results
  int         stb_cnt, rdv_cnt, done_cnt, gap_cnt;
  logic [4:0] adr_log [$];
  logic [31:0] mon_dat;
  logic [1:0] mon_status;

  task automatic clear_mon();
    stb_cnt = 0; rdv_cnt = 0; done_cnt = 0; gap_cnt = 0;
    adr_log.delete();
    mon_dat = '0;
    mon_status = 2'b11;
  endtask

  // slave: wait sl_lo..sl_hi cycles per beat, then ack (plus err on sl_err_beat)
  initial begin
    int waited, cur_wait;
    ack_in = 1'b0; err_in = 1'b0; dat_in = '0;
    waited = 0; cur_wait = 0;
    forever begin
      @(posedge clk_in); #1;
      if (!rst_n_in || !stb_o) begin
        ack_in = 1'b0; err_in = 1'b0; waited = 0;
        cur_wait = int'($urandom_range(sl_hi, sl_lo));
      end else if (waited >= cur_wait) begin
        ack_in = 1'b1;
        err_in = (sl_beat == sl_err_beat);
        dat_in = $urandom;
        sl_beat++;
        waited = 0;
        cur_wait = int'($urandom_range(sl_hi, sl_lo));
      end else begin
        ack_in = 1'b0; err_in = 1'b0;
        waited++;
      end
    end
  end

  // model: next-cycle bus outputs derived from this cycle's inputs
  logic        busy, m_we, e_stb, e_cyc, e_done, e_rdv;
  logic        n_stb, n_cyc, n_done, n_rdv;
  logic [4:0]  m_adr, e_adr;
  logic [3:0]  m_sel;
  logic [31:0] m_dat, e_rdd;
  logic [1:0]  e_status;
  int          m_len, beat, tcount;

  initial begin
    busy = 0; m_we = 0; e_stb = 0; e_cyc = 0; e_done = 0; e_rdv = 0;
    m_adr = '0; m_sel = '0; m_dat = '0; e_rdd = '0; e_status = 2'b00;
    m_len = 0; beat = 0; tcount = 0;
    forever begin
      @(negedge clk_in);
      if (!rst_n_in) begin
        chk("rst_cyc", cyc_o, 0);          chk("rst_stb", stb_o, 0);
        chk("rst_we", we_o, 0);            chk("rst_adr", adr_o, 0);
        chk("rst_dat", dat_o, 0);          chk("rst_sel", sel_o, 0);
        chk("rst_rd_dat", rd_dat_o, 0);    chk("rst_rd_valid", rd_valid_o, 0);
        chk("rst_done", done_o, 0);        chk("rst_status", status_o, 0);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_wr_ready", wr_ready_o, 0);
        busy = 0; e_stb = 0; e_cyc = 0; e_done = 0; e_rdv = 0; e_status = 2'b00;
        continue;
      end
      chk("cmd_ready", cmd_ready_o, !busy);
      chk("wr_ready", wr_ready_o, busy && m_we && !e_stb && !e_done);
      chk("stb", stb_o, e_stb);
      chk("cyc", cyc_o, e_cyc);
      chk("done", done_o, e_done);
      chk("status", status_o, e_status);
      chk("rd_valid", rd_valid_o, e_rdv);
      if (e_rdv) chk("rd_dat", rd_dat_o, e_rdd);
      if (e_stb) begin
        e_adr = m_adr + 5'(beat);
        chk("adr", adr_o, e_adr);
        chk("sel", sel_o, m_sel);
        chk("we", we_o, m_we);
        if (m_we) chk("wdat", dat_o, m_dat);
      end

      if (stb_o) begin stb_cnt++; adr_log.push_back(adr_o); mon_dat = dat_o; end
      if (cyc_o && !stb_o) gap_cnt++;
      if (rd_valid_o) rdv_cnt++;
      if (done_o) begin done_cnt++; mon_status = status_o; end

      n_stb = e_stb; n_cyc = e_cyc; n_done = 0; n_rdv = 0;
      if (e_done) begin
        busy = 0; n_stb = 0; n_cyc = 0;
      end else if (!busy) begin
        if (cmd_valid_in) begin
          busy = 1; m_we = cmd_we_in; m_adr = cmd_adr_in; m_sel = cmd_sel_in;
          m_len = int'(cmd_len_in); beat = 0; tcount = 0;
          n_stb = !cmd_we_in; n_cyc = !cmd_we_in;
        end
      end else if (e_stb) begin
        if (err_in) begin
          n_stb = 0; n_cyc = 0; n_done = 1; e_status = 2'b01;
        end else if (ack_in) begin
          tcount = 0;
          if (!m_we) begin n_rdv = 1; e_rdd = dat_in; end
          if (beat == m_len) begin
            n_stb = 0; n_cyc = 0; n_done = 1; e_status = 2'b00;
          end else begin
            beat++;
            if (m_we) n_stb = 0;
          end
        end else begin
          tcount++;
          if (TO_EN && tcount >= TO) begin
            n_stb = 0; n_cyc = 0; n_done = 1; e_status = 2'b10;
          end
        end
      end else if (wr_valid_in) begin
        n_stb = 1; n_cyc = 1; m_dat = wr_dat_in; tcount = 0;
      end
      e_stb = n_stb; e_cyc = n_cyc; e_done = n_done; e_rdv = n_rdv;
    end
  end

  logic [31:0] wd [MAX_LEN];
  bit          fixed_wd = 0;

  // issue one command, feed its write beats (optionally stalling one beat), await done_o
  task automatic run_cmd(input logic we, input logic [4:0] adr, input logic [3:0] sel,
                         input int len, input int stall_beat, input int stall_cyc);
    int k, st, n;
    bit acc, fin, hs;
    k = 0; st = 0; n = 0; acc = 0; fin = 0;
    if (!fixed_wd) for (int i = 0; i < MAX_LEN; i++) wd[i] = $urandom;
    sl_beat = 0;
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b1; cmd_we_in = we; cmd_adr_in = adr; cmd_sel_in = sel;
    cmd_len_in = len[3:0];
    while (!fin && n < 4000) begin
      @(negedge clk_in);
      if (cmd_valid_in && cmd_ready_o) acc = 1;
      hs = wr_valid_in && wr_ready_o;
      if (done_o) fin = 1;
      @(posedge clk_in); #1;
      if (acc) cmd_valid_in = 1'b0;
      if (hs) begin k++; st = 0; end
      wr_valid_in = 1'b0;
      if (we && acc && !fin && k <= len) begin
        if (wr_ready_o && k == stall_beat && st < stall_cyc) st++;
        else begin wr_valid_in = 1'b1; wr_dat_in = wd[k]; end
      end
      n++;
    end
    if (!fin) chk("done_within_budget", 0, 1);
    wr_valid_in = 1'b0;
    cmd_valid_in = 1'b0;
  endtask

  logic [4:0] seq_rd [4];
  int         rl, rsb, d0;
  logic       rwe;

  initial begin
    seq_rd[0] = 5'h1E; seq_rd[1] = 5'h1F; seq_rd[2] = 5'h00; seq_rd[3] = 5'h01;
    cmd_valid_in = 0; cmd_we_in = 0; cmd_adr_in = '0; cmd_sel_in = '0; cmd_len_in = '0;
    wr_valid_in = 0; wr_dat_in = '0;
    clear_mon();
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);

    // single write, two wait states
    clear_mon();
    fixed_wd = 1; wd[0] = 32'hDEADBEEF;
    sl_lo = 2; sl_hi = 2; sl_err_beat = -1;
    run_cmd(1'b1, 5'h03, 4'hF, 0, -1, 0);
    fixed_wd = 0;
    chk("wr1_stb_cycles", stb_cnt, 3);
    chk("wr1_adr", adr_log.size() > 0 ? adr_log[0] : 5'h1F, 5'h03);
    chk("wr1_dat", mon_dat, 32'hDEADBEEF);
    chk("wr1_status", mon_status, 2'b00);
    chk("wr1_done_cnt", done_cnt, 1);

    // 4-beat read across the address wrap, zero-wait slave
    clear_mon();
    sl_lo = 0; sl_hi = 0;
    run_cmd(1'b0, 5'h1E, 4'hF, 3, -1, 0);
    chk("rd4_stb_cycles", stb_cnt, 4);
    chk("rd4_rd_valid_cnt", rdv_cnt, 4);
    chk("rd4_adr_cnt", adr_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < adr_log.size()) chk("rd4_adr_seq", adr_log[i], seq_rd[i]);
    chk("rd4_status", mon_status, 2'b00);

    // 3-beat write with the second beat's data withheld 3 cycles
    clear_mon();
    run_cmd(1'b1, 5'h10, 4'h5, 2, 1, 3);
    chk("wrs_stb_cycles", stb_cnt, 3);
    chk("wrs_cyc_gap_cycles", gap_cnt, 5);
    chk("wrs_done_cnt", done_cnt, 1);
    chk("wrs_status", mon_status, 2'b00);

    // read len=3 with ack+err on the second beat
    clear_mon();
    sl_err_beat = 1;
    run_cmd(1'b0, 5'h04, 4'hC, 3, -1, 0);
    sl_err_beat = -1;
    chk("err_rd_valid_cnt", rdv_cnt, 1);
    chk("err_stb_cycles", stb_cnt, 2);
    chk("err_status", mon_status, 2'b01);

    // slave that stays silent for 1000 cycles
    clear_mon();
    sl_lo = 1000; sl_hi = 1000;
    run_cmd(1'b0, 5'h07, 4'hF, 0, -1, 0);
`ifdef WB_TIMEOUT_EN
    chk("to_stb_cycles", stb_cnt, TO);
    chk("to_status", mon_status, 2'b10);
`else
    chk("noto_stb_cycles", stb_cnt, 1001);
    chk("noto_status", mon_status, 2'b00);
`endif

    // randomized commands
    for (int t = 0; t < 40; t++) begin
      rl  = int'($urandom_range(15, 0));
      rwe = 1'($urandom_range(1, 0));
      sl_lo = 0; sl_hi = int'($urandom_range(3, 0));
      sl_err_beat = ($urandom_range(4, 0) == 0) ? int'($urandom_range(rl, 0)) : -1;
      rsb = ($urandom_range(1, 0) == 1) ? int'($urandom_range(rl, 0)) : -1;
      clear_mon();
      run_cmd(rwe, 5'($urandom), 4'($urandom), rl, rsb, int'($urandom_range(3, 0)));
      chk("rnd_done_cnt", done_cnt, 1);
    end
    sl_err_beat = -1;

    // reset in the middle of an 8-beat read
    clear_mon();
    sl_lo = 1; sl_hi = 1; sl_beat = 0;
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b1; cmd_we_in = 1'b0; cmd_adr_in = 5'h08; cmd_sel_in = 4'h3; cmd_len_in = 4'd7;
    @(posedge clk_in); #1;
    cmd_valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #3;
    chk("prerst_stb", stb_o, 1);
    rst_n_in = 1'b0;
    #1;
    chk("midrst_cyc", cyc_o, 0);
    chk("midrst_stb", stb_o, 0);
    chk("midrst_cmd_ready", cmd_ready_o, 1);
    d0 = done_cnt;
    repeat (3) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    repeat (3) @(posedge clk_in);
    chk("midrst_no_done", done_cnt, d0);

    // normal command after the reset
    clear_mon();
    sl_lo = 0; sl_hi = 1;
    run_cmd(1'b0, 5'h02, 4'hF, 2, -1, 0);
    chk("postrst_rd_valid_cnt", rdv_cnt, 3);
    chk("postrst_status", mon_status, 2'b00);

    repeat (3) @(posedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
